// File: rtl/upgrade_pkg.sv
// rtl/upgrade_pkg.sv - shared types, constants and hitbox helper for the power-up item engine
package upgrade_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        WALK = 2'd2,
        GONE = 2'd3
    } upgrade_state_t;

    localparam int SPRITE_ADDR_W = 9;

    // Strict AABB: boxes that only share an edge do not overlap.
    function automatic logic aabb_overlap(
        input logic [10:0] ax, input logic [10:0] ay,
        input logic [10:0] aw, input logic [10:0] ah,
        input logic [10:0] bx, input logic [10:0] by,
        input logic [10:0] bw, input logic [10:0] bh
    );
        return (ax < bx + bw) && (bx < ax + aw) &&
               (ay < by + bh) && (by < ay + ah);
    endfunction

endpackage

// File: rtl/upgrade_motion_if.sv
// rtl/upgrade_motion_if.sv - game-side bus between the level logic and one power-up item engine
interface upgrade_motion_if;
    import upgrade_pkg::*;

    logic                     frame_clk;
    logic [9:0]               DrawX;
    logic [9:0]               DrawY;
    logic [2:0]               level_num;
    logic                     is_qblock_empty;
    logic [9:0]               mario_x;
    logic [9:0]               mario_y;
    logic [9:0]               luigi_x;
    logic [9:0]               luigi_y;
    logic [9:0]               mario_Size_Y;
    logic [9:0]               luigi_Size_Y;
    logic [1:0]               mario_health;
    logic [1:0]               luigi_health;
    logic                     is_upgrade;
    logic [9:0]               upgrade_X_Pos;
    logic [9:0]               upgrade_Y_Pos;
    logic [SPRITE_ADDR_W-1:0] upgrade_address;
    logic                     collect_mario;
    logic                     collect_luigi;

    modport master (
        output frame_clk, DrawX, DrawY, level_num, is_qblock_empty,
               mario_x, mario_y, luigi_x, luigi_y, mario_Size_Y, luigi_Size_Y,
               mario_health, luigi_health,
        input  is_upgrade, upgrade_X_Pos, upgrade_Y_Pos, upgrade_address,
               collect_mario, collect_luigi
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, level_num, is_qblock_empty,
               mario_x, mario_y, luigi_x, luigi_y, mario_Size_Y, luigi_Size_Y,
               mario_health, luigi_health,
        output is_upgrade, upgrade_X_Pos, upgrade_Y_Pos, upgrade_address,
               collect_mario, collect_luigi
    );

endinterface

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - brings an asynchronous frame strobe into clk_i as a one-cycle tick
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic tick_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign tick_o = sync_q & ~prev_q;

endmodule

// File: rtl/upgrade_motion.sv
// rtl/upgrade_motion.sv - power-up mushroom: emerges from its question block, walks, is collected
module upgrade_motion
    import upgrade_pkg::*;
#(
    parameter logic [2:0] ROOM_NUM = 3'b001,
    parameter logic [9:0] START_X  = 10'd100,
    parameter logic [9:0] START_Y  = 10'd342,
    parameter logic [9:0] SIZE     = 10'd16,
    parameter logic [9:0] SPEED_X  = 10'd1,
    parameter logic [9:0] X_MIN    = 10'd0,
    parameter logic [9:0] X_MAX    = 10'd639,
    parameter logic [9:0] PLAYER_W = 10'd16
) (
    input  logic           Clk,
    input  logic           Reset,
    upgrade_motion_if.slave bus
);

    localparam logic [9:0]  RISE_TOP    = START_Y - SIZE;
    localparam logic [10:0] X_RIGHT_LIM = {1'b0, X_MAX} - {1'b0, SIZE} + 11'd1;

    upgrade_state_t state_q;
    logic [9:0]     x_q;
    logic [9:0]     y_q;
    logic           dir_right_q;
    logic           qblock_q;
    logic           collect_mario_q;
    logic           collect_luigi_q;

    logic           frame_tick;
    logic           active;
    logic           qblock_rise;
    logic [9:0]     y_dec;
    logic [10:0]    x_ext;
    logic [10:0]    x_right;
    logic [9:0]     x_walk_d;
    logic           dir_walk_d;
    logic           mario_hit;
    logic           luigi_hit;
    logic           in_box;
    logic           visible;
    logic [9:0]     dx;
    logic [9:0]     dy;

    frame_tick_sync u_frame_tick_sync (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .async_i(bus.frame_clk),
        .tick_o (frame_tick)
    );

    assign active      = (bus.level_num == ROOM_NUM);
    assign qblock_rise = bus.is_qblock_empty & ~qblock_q;
    assign y_dec       = y_q - 10'd1;
    assign x_ext       = {1'b0, x_q};
    assign x_right     = x_ext + {1'b0, SPEED_X};

    // Next walking position; 11-bit math so neither wall check can wrap.
    always_comb begin
        x_walk_d   = x_q;
        dir_walk_d = dir_right_q;
        if (dir_right_q) begin
            if (x_right > X_RIGHT_LIM) begin
                x_walk_d   = X_RIGHT_LIM[9:0];
                dir_walk_d = 1'b0;
            end else begin
                x_walk_d   = x_right[9:0];
            end
        end else begin
            if (x_ext < ({1'b0, X_MIN} + {1'b0, SPEED_X})) begin
                x_walk_d   = X_MIN;
                dir_walk_d = 1'b1;
            end else begin
                x_walk_d   = x_q - SPEED_X;
            end
        end
    end

    assign mario_hit = (bus.mario_health != 2'd0) &&
        aabb_overlap({1'b0, bus.mario_x}, {1'b0, bus.mario_y},
                     {1'b0, PLAYER_W}, {1'b0, bus.mario_Size_Y},
                     x_ext, {1'b0, y_q}, {1'b0, SIZE}, {1'b0, SIZE});
    assign luigi_hit = (bus.luigi_health != 2'd0) &&
        aabb_overlap({1'b0, bus.luigi_x}, {1'b0, bus.luigi_y},
                     {1'b0, PLAYER_W}, {1'b0, bus.luigi_Size_Y},
                     x_ext, {1'b0, y_q}, {1'b0, SIZE}, {1'b0, SIZE});

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= IDLE;
            x_q             <= START_X;
            y_q             <= START_Y;
            dir_right_q     <= 1'b1;
            qblock_q        <= 1'b0;
            collect_mario_q <= 1'b0;
            collect_luigi_q <= 1'b0;
        end else begin
            collect_mario_q <= 1'b0;
            collect_luigi_q <= 1'b0;
            // Leaving the room freezes everything, including the arming edge detector.
            if (active) begin
                qblock_q <= bus.is_qblock_empty;
                case (state_q)
                    IDLE: begin
                        if (qblock_rise) begin
                            state_q <= RISE;
                        end
                    end
                    RISE: begin
                        if (frame_tick) begin
                            y_q <= y_dec;
                            if (y_dec == RISE_TOP) begin
                                state_q <= WALK;
                            end
                        end
                    end
                    WALK: begin
                        if (frame_tick) begin
                            if (mario_hit) begin
                                collect_mario_q <= 1'b1;
                                state_q         <= GONE;
                            end else if (luigi_hit) begin
                                collect_luigi_q <= 1'b1;
                                state_q         <= GONE;
                            end else begin
                                x_q         <= x_walk_d;
                                dir_right_q <= dir_walk_d;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_box = ({1'b0, bus.DrawX} >= x_ext) &&
                    ({1'b0, bus.DrawX} < x_ext + {1'b0, SIZE}) &&
                    ({1'b0, bus.DrawY} >= {1'b0, y_q}) &&
                    ({1'b0, bus.DrawY} < {1'b0, y_q} + {1'b0, SIZE});

    // While emerging, rows at or below the block top stay hidden behind it.
    assign visible = active && in_box &&
                     ((state_q == WALK) ||
                      ((state_q == RISE) && (bus.DrawY < START_Y)));

    assign dx = bus.DrawX - x_q;
    assign dy = bus.DrawY - y_q;

    assign bus.is_upgrade      = visible;
    assign bus.upgrade_X_Pos   = x_q;
    assign bus.upgrade_Y_Pos   = y_q;
    assign bus.upgrade_address = visible ? SPRITE_ADDR_W'(dy * SIZE + dx) : '0;
    assign bus.collect_mario   = collect_mario_q;
    assign bus.collect_luigi   = collect_luigi_q;

endmodule

// File: tb/tb_upgrade_motion.sv
// tb/tb_upgrade_motion.sv - directed self-checking bench for the power-up item engine
module tb_upgrade_motion;
    import upgrade_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cm_cnt = 0;
    int   cl_cnt = 0;
    int   tick_cnt = 0;

    upgrade_motion_if bus ();

    upgrade_motion dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (bus.collect_mario) cm_cnt++;
        if (bus.collect_luigi) cl_cnt++;
        if (dut.frame_tick)    tick_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick(input int hi = 4);
        @(posedge Clk);
        #1 bus.frame_clk = 1'b1;
        repeat (hi) @(posedge Clk);
        #1 bus.frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic far_players();
        bus.mario_x = 10'd0;  bus.mario_y = 10'd0;
        bus.luigi_x = 10'd0;  bus.luigi_y = 10'd0;
        bus.mario_Size_Y = 10'd32; bus.luigi_Size_Y = 10'd32;
        bus.mario_health = 2'd2;   bus.luigi_health = 2'd2;
    endtask

    task automatic walk_to(input int target, input string tag);
        int n;
        n = 0;
        while (int'(bus.upgrade_X_Pos) != target && n < 700) begin
            do_tick();
            n++;
        end
        check_eq(tag, int'(bus.upgrade_X_Pos), target);
    endtask

    int cm0, cl0, tk0;

    initial begin
        bus.frame_clk = 1'b0;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
        bus.level_num = 3'd1;
        bus.is_qblock_empty = 1'b0;
        far_players();

        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_state", int'(dut.state_q), int'(IDLE));
        check_eq("rst_x", int'(bus.upgrade_X_Pos), 100);
        check_eq("rst_y", int'(bus.upgrade_Y_Pos), 342);
        check_eq("rst_draw", int'(bus.is_upgrade), 0);
        check_eq("rst_cm", int'(bus.collect_mario), 0);
        Reset = 1'b0;

        @(posedge Clk); #1 bus.is_qblock_empty = 1'b1;
        @(posedge Clk); #1;
        check_eq("arm_rise", int'(dut.state_q), int'(RISE));

        repeat (5) do_tick();
        check_eq("rise5_y", int'(bus.upgrade_Y_Pos), 337);
        bus.level_num = 3'd2;
        bus.DrawX = 10'd105; bus.DrawY = 10'd340;
        repeat (3) do_tick();
        check_eq("away_y", int'(bus.upgrade_Y_Pos), 337);
        check_eq("away_draw", int'(bus.is_upgrade), 0);
        bus.level_num = 3'd1;
        #1;
        check_eq("back_draw", int'(bus.is_upgrade), 1);
        check_eq("back_addr", int'(bus.upgrade_address), 53);
        do_tick();
        check_eq("resume_y", int'(bus.upgrade_Y_Pos), 336);

        repeat (6) do_tick();
        bus.DrawX = 10'd105; bus.DrawY = 10'd335;
        #1;
        check_eq("rise12_y", int'(bus.upgrade_Y_Pos), 330);
        check_eq("rise12_draw", int'(bus.is_upgrade), 1);
        check_eq("rise12_addr", int'(bus.upgrade_address), 85);
        bus.DrawY = 10'd342;
        #1;
        check_eq("rise_hidden", int'(bus.is_upgrade), 0);
        check_eq("rise_hidden_addr", int'(bus.upgrade_address), 0);

        repeat (4) do_tick();
        check_eq("rise16_y", int'(bus.upgrade_Y_Pos), 326);
        check_eq("rise16_walk", int'(dut.state_q), int'(WALK));
        check_eq("rise16_x", int'(bus.upgrade_X_Pos), 100);

        bus.mario_x = 10'd84; bus.mario_y = 10'd320;
        cm0 = cm_cnt;
        do_tick();
        check_eq("edge_nocol", cm_cnt - cm0, 0);
        check_eq("edge_x", int'(bus.upgrade_X_Pos), 101);
        check_eq("edge_walk", int'(dut.state_q), int'(WALK));

        bus.mario_x = 10'd101; bus.mario_health = 2'd0;
        cm0 = cm_cnt;
        do_tick();
        check_eq("dead_nocol", cm_cnt - cm0, 0);
        check_eq("dead_x", int'(bus.upgrade_X_Pos), 102);
        far_players();

        tk0 = cm_cnt; tk0 = tick_cnt;
        do_tick(60);
        check_eq("long_high_ticks", tick_cnt - tk0, 1);
        check_eq("long_high_x", int'(bus.upgrade_X_Pos), 103);

        walk_to(620, "walk620");
        repeat (4) do_tick();
        check_eq("wall_x624", int'(bus.upgrade_X_Pos), 624);
        do_tick();
        check_eq("wall_clamp", int'(bus.upgrade_X_Pos), 624);
        check_eq("wall_dir", int'(dut.dir_right_q), 0);
        do_tick();
        check_eq("wall_back", int'(bus.upgrade_X_Pos), 623);

        walk_to(115, "walk115");
        bus.mario_x = 10'd110; bus.mario_y = 10'd320;
        bus.luigi_x = 10'd115; bus.luigi_y = 10'd320;
        cm0 = cm_cnt; cl0 = cl_cnt;
        do_tick();
        check_eq("col_mario", cm_cnt - cm0, 1);
        check_eq("col_luigi", cl_cnt - cl0, 0);
        check_eq("col_gone", int'(dut.state_q), int'(GONE));
        check_eq("col_x", int'(bus.upgrade_X_Pos), 115);
        bus.DrawX = 10'd120; bus.DrawY = 10'd330;
        #1;
        check_eq("gone_draw", int'(bus.is_upgrade), 0);
        bus.is_qblock_empty = 1'b0;
        repeat (2) @(posedge Clk);
        #1 bus.is_qblock_empty = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("gone_stays", int'(dut.state_q), int'(GONE));
        far_players();

        bus.is_qblock_empty = 1'b0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk); #1 bus.is_qblock_empty = 1'b1;
        repeat (16) do_tick();
        walk_to(300, "walk300");
        bus.DrawX = 10'd305; bus.DrawY = 10'd330;
        #1;
        check_eq("pre_rst_draw", int'(bus.is_upgrade), 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check_eq("mid_rst_state", int'(dut.state_q), int'(IDLE));
        check_eq("mid_rst_x", int'(bus.upgrade_X_Pos), 100);
        check_eq("mid_rst_y", int'(bus.upgrade_Y_Pos), 342);
        check_eq("mid_rst_draw", int'(bus.is_upgrade), 0);
        check_eq("mid_rst_cm", int'(bus.collect_mario), 0);
        check_eq("mid_rst_cl", int'(bus.collect_luigi), 0);
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
